// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath select encodings and the bundle of Moore control outputs.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_source_e;

  // Outputs that depend on state only; IRWrite and the fetch PC update are
  // gated with MemReady separately in the top.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    pc_source_e pc_source;
    alu_op_e    alu_op;
    alu_src_b_e alu_src_b;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle controller, including
// detection of opcodes the controller does not support.
module mc_next_state
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output state_e     next_state,
  output logic       illegal_op
);

  always_comb begin
    next_state = S_IDLE;
    illegal_op = 1'b0;
    case (state_e'(state))
      S_IDLE:    next_state = S_FETCH;
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(op)) begin
          next_state = S_MEMADR;
        end else begin
          case (op)
            OP_RTYPE: next_state = S_EXECUTE;
            OP_BEQ:   next_state = S_BRANCH;
            OP_J:     next_state = S_JUMP;
            default: begin
              next_state = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR:  next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      // Unused encodings recover through IDLE.
      default:   next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register, sticky illegal-opcode flag
// and registered Moore output decode.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State,
  output logic       Illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_op;
  logic   fetch_done;

  mc_next_state u_next_state (
    .state      (state_q),
    .op         (Op),
    .mem_ready  (MemReady),
    .next_state (state_d),
    .illegal_op (illegal_op)
  );

  assign illegal_d = illegal_q | illegal_op;

  // Outputs are decoded from the state being entered so the registered copy
  // lines up with state_q in the same cycle.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_REG;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REG;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PCSRC_JUMP;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Instruction register and PC latch only in the cycle the fetch completes.
  assign fetch_done = (state_q == S_FETCH) && MemReady;

  assign PCWrite     = ctrl_q.pc_write | fetch_done;
  assign IRWrite     = fetch_done;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.ior_d;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ctrl_q.alu_op;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign State       = state_q;
  assign Illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference
// model expands each instruction into its expected per-cycle state trace.
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;
  logic       Illegal;

  int total = 0;
  int bad   = 0;

  // Entry: {illegal_expected, mem_ready, op, state}
  logic [11:0] exp_q[$];
  logic        model_ill = 1'b0;

  multicycle_control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Op          (Op),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .State       (State),
    .Illegal     (Illegal)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] obs_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
  endfunction

  // Control table by state number, straight from the output rules.
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcsrc, aluop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst} = '0;
    pcsrc = 2'd0; aluop = 2'd0; srcb = 2'd0;
    case (st)
      1:  begin mrd = 1; srcb = 2'd1; irw = mr; pcw = mr; end
      2:  srcb = 2'd3;
      3:  begin srca = 1; srcb = 2'd2; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin srca = 1; aluop = 2'd2; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin srca = 1; aluop = 2'd1; pcwc = 1; pcsrc = 2'd1; end
      10: begin pcw = 1; pcsrc = 2'd2; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcsrc, aluop, srcb};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input int st, input logic mr, input logic [5:0] op);
    exp_q.push_back({model_ill, mr, op, 4'(st)});
  endtask

  // Expands one instruction into its expected cycle trace.
  task automatic enqueue_instr(input logic [5:0] op, input int fs, input int ms);
    for (int i = 0; i < fs; i++) push(1, 1'b0, rnd_op());
    push(1, 1'b1, rnd_op());
    push(2, rnd_bit(), op);
    case (op)
      6'h23: begin
        push(3, rnd_bit(), op);
        for (int i = 0; i < ms; i++) push(4, 1'b0, rnd_op());
        push(4, 1'b1, rnd_op());
        push(5, rnd_bit(), rnd_op());
      end
      6'h2B: begin
        push(3, rnd_bit(), op);
        for (int i = 0; i < ms; i++) push(6, 1'b0, rnd_op());
        push(6, 1'b1, rnd_op());
      end
      6'h00: begin
        push(7, rnd_bit(), rnd_op());
        push(8, rnd_bit(), rnd_op());
      end
      6'h04: push(9, rnd_bit(), rnd_op());
      6'h02: push(10, rnd_bit(), rnd_op());
      default: model_ill = 1'b1;
    endcase
  endtask

  task automatic run_queue(input string tag);
    logic [11:0] e;
    logic [15:0] want;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clk);
      MemReady = e[10];
      Op       = e[9:4];
      #1;
      want = exp_ctrl(int'(e[3:0]), e[10]);
      total++;
      if (State !== e[3:0]) begin
        bad++;
        $display("FAIL %s state: got %0d want %0d", tag, State, e[3:0]);
      end
      total++;
      if (obs_ctrl() !== want) begin
        bad++;
        $display("FAIL %s ctrl (state %0d): got %h want %h", tag, e[3:0], obs_ctrl(), want);
      end
      total++;
      if (Illegal !== e[11]) begin
        bad++;
        $display("FAIL %s illegal: got %b want %b", tag, Illegal, e[11]);
      end
      total++;
      if (((MemRead & MemWrite) | (RegWrite & PCWrite)) !== 1'b0) begin
        bad++;
        $display("FAIL %s exclusive: got mr=%b mw=%b rw=%b pcw=%b want no overlap",
                 tag, MemRead, MemWrite, RegWrite, PCWrite);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (State !== 4'd0 || obs_ctrl() !== 16'h0 || Illegal !== 1'b0) begin
      bad++;
      $display("FAIL %s: got state=%0d ctrl=%h ill=%b want 0/0000/0", tag, State, obs_ctrl(), Illegal);
    end
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset    = 1'b0;
    MemReady = 1'b0;
    #1;
    model_ill = 1'b0;
    check_all_zero("idle_after_release");
  endtask

  task automatic test_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_all_zero("reset_assert");
    release_reset();
  endtask

  // Waits (bounded) for a given state, sampling mid-cycle.
  task automatic wait_state(input logic [3:0] st, input string tag);
    int n = 0;
    while (State !== st && n < 20) begin
      @(negedge Clk); #1; n++;
    end
    total++;
    if (State !== st) begin
      bad++;
      $display("FAIL %s timeout: got %0d want %0d", tag, State, st);
    end
  endtask

  task automatic test_latency();
    logic [5:0] ops [5] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
    int         lat [5] = '{5, 4, 4, 3, 3};
    int n;
    MemReady = 1'b1;
    Op = ops[0];
    wait_state(4'd1, "lat_start");
    for (int k = 0; k < 5; k++) begin
      Op = ops[k];
      n = 0;
      do begin
        @(negedge Clk); #1; n++;
      end while (State !== 4'd1 && n < 20);
      total++;
      if (n !== lat[k]) begin
        bad++;
        $display("FAIL latency op=%h: got %0d want %0d", ops[k], n, lat[k]);
      end
    end
    test_reset();
  endtask

  task automatic test_reset_mid_memwr();
    MemReady = 1'b1;
    Op = 6'h2B;
    wait_state(4'd6, "reach_memwr");
    MemReady = 1'b0;
    @(negedge Clk); #1;
    total++;
    if (State !== 4'd6 || MemWrite !== 1'b1) begin
      bad++;
      $display("FAIL memwr_stall: got state=%0d mw=%b want 6/1", State, MemWrite);
    end
    #2 Reset = 1'b1;
    #1 check_all_zero("reset_mid_memwr");
    release_reset();
    @(posedge Clk); #1;
    total++;
    if (State !== 4'd1) begin
      bad++;
      $display("FAIL fetch_after_reset: got %0d want 1", State);
    end
    test_reset();
  endtask

  task automatic test_reset_mid_fetch();
    enqueue_instr(6'h3F, 0, 0);
    run_queue("pre_fetch_reset");
    @(negedge Clk);
    MemReady = 1'b0;
    #1;
    total++;
    if (State !== 4'd1 || Illegal !== 1'b1) begin
      bad++;
      $display("FAIL fetch_stall_pre: got state=%0d ill=%b want 1/1", State, Illegal);
    end
    #2 Reset = 1'b1;
    #1 check_all_zero("reset_mid_fetch");
    release_reset();
  endtask

  task automatic test_directed();
    enqueue_instr(6'h23, 0, 0);
    run_queue("lw");
    enqueue_instr(6'h2B, 0, 3);
    run_queue("sw_stall");
    enqueue_instr(6'h04, 2, 0);
    run_queue("fetch_stall");
    enqueue_instr(6'h04, 0, 0);
    enqueue_instr(6'h02, 0, 0);
    run_queue("beq_j");
    enqueue_instr(6'h3F, 0, 0);
    enqueue_instr(6'h00, 0, 0);
    run_queue("illegal_sticky");
  endtask

  task automatic test_random();
    logic [5:0] legal [5] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
    logic [5:0] op;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd_op();
        while (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h02);
      end else begin
        op = legal[$urandom_range(0, 4)];
      end
      enqueue_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_queue("random");
  endtask

  initial begin
    Reset    = 1'b1;
    MemReady = 1'b0;
    Op       = 6'h00;
    #1 check_all_zero("power_on_reset");
    test_reset();
    test_latency();
    test_directed();
    test_reset();
    test_reset_mid_memwr();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
